// File: rtl/memory_writeback_pipe.sv
// rtl/memory_writeback_pipe.sv - memory-to-writeback pipeline register, STAGES deep
// Optional register forwarding lookup across all stages: define MEM_WB_FORWARD_EN.
// Stage 0 is nearest the memory stage; stage STAGES-1 drives the *_writeback outputs.
module memory_writeback_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int STAGES       = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ALU_result_memory,
  input  logic [DATA_WIDTH-1:0] load_data_memory,
  input  logic                  opwrite_memory,
  input  logic                  opsel_memory,
  input  logic [4:0]            opReg_memory,
  input  logic                  valid_memory,
  input  logic                  stall,
  input  logic                  flush,
`ifdef MEM_WB_FORWARD_EN
  input  logic [4:0]            fwd_rs1,
  input  logic [4:0]            fwd_rs2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic [DATA_WIDTH-1:0] fwd_data2,
`endif
  output logic [DATA_WIDTH-1:0] ALU_result_writeback,
  output logic [DATA_WIDTH-1:0] load_data_writeback,
  output logic                  opwrite_writeback,
  output logic                  opsel_writeback,
  output logic [4:0]            opReg_writeback,
  output logic                  valid_writeback,
  output logic [DATA_WIDTH-1:0] writeback_data
);

  // Only 1..4 stages are supported; ADDRESS_BITS exists for sibling compatibility.
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("memory_writeback_pipe: STAGES must be in 1..4");
  end
  if (ADDRESS_BITS < 1) begin : g_bad_address_bits
    $error("memory_writeback_pipe: ADDRESS_BITS must be positive");
  end

  logic [DATA_WIDTH-1:0] alu_q    [STAGES];
  logic [DATA_WIDTH-1:0] load_q   [STAGES];
  logic                  opwrite_q[STAGES];
  logic                  opsel_q  [STAGES];
  logic [4:0]            opreg_q  [STAGES];
  logic                  valid_q  [STAGES];

  // A write is only ever carried for a real instruction targeting a non-zero register,
  // so every later stage can trust opwrite without re-checking valid or x0.
  logic opwrite_in;
  assign opwrite_in = opwrite_memory & valid_memory & (opReg_memory != 5'd0);

  // Stage registers: reset > flush > stall > advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        alu_q[k]     <= '0;
        load_q[k]    <= '0;
        opwrite_q[k] <= 1'b0;
        opsel_q[k]   <= 1'b0;
        opreg_q[k]   <= 5'd0;
        valid_q[k]   <= 1'b0;
      end
    end else if (flush) begin
      // Killing valid and opwrite is enough; stale data fields are never consumed.
      for (int k = 0; k < STAGES; k++) begin
        opwrite_q[k] <= 1'b0;
        valid_q[k]   <= 1'b0;
      end
    end else if (!stall) begin
      alu_q[0]     <= ALU_result_memory;
      load_q[0]    <= load_data_memory;
      opwrite_q[0] <= opwrite_in;
      opsel_q[0]   <= opsel_memory;
      opreg_q[0]   <= opReg_memory;
      valid_q[0]   <= valid_memory;
      for (int k = 1; k < STAGES; k++) begin
        alu_q[k]     <= alu_q[k-1];
        load_q[k]    <= load_q[k-1];
        opwrite_q[k] <= opwrite_q[k-1];
        opsel_q[k]   <= opsel_q[k-1];
        opreg_q[k]   <= opreg_q[k-1];
        valid_q[k]   <= valid_q[k-1];
      end
    end
  end

  assign ALU_result_writeback = alu_q[STAGES-1];
  assign load_data_writeback  = load_q[STAGES-1];
  assign opwrite_writeback    = opwrite_q[STAGES-1];
  assign opsel_writeback      = opsel_q[STAGES-1];
  assign opReg_writeback      = opreg_q[STAGES-1];
  assign valid_writeback      = valid_q[STAGES-1];
  assign writeback_data       = opsel_q[STAGES-1] ? load_q[STAGES-1] : alu_q[STAGES-1];

`ifdef MEM_WB_FORWARD_EN
  // Forwarding lookup: scan oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (valid_q[k] && opwrite_q[k] && (fwd_rs1 != 5'd0) && (opreg_q[k] == fwd_rs1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = opsel_q[k] ? load_q[k] : alu_q[k];
      end
      if (valid_q[k] && opwrite_q[k] && (fwd_rs2 != 5'd0) && (opreg_q[k] == fwd_rs2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = opsel_q[k] ? load_q[k] : alu_q[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_memory_writeback_pipe.sv
// tb/tb_memory_writeback_pipe.sv - randomized self-checking bench for memory_writeback_pipe
// Two instances (STAGES = 2 and 3) share stimulus; MEM_WB_FORWARD_EN also checks forwarding.
module tb_memory_writeback_pipe;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, stall, flush;
  logic [31:0] alu_m, load_m;
  logic        opwrite_m, opsel_m, valid_m;
  logic [4:0]  reg_m;

  logic [31:0] alu_o [2];
  logic [31:0] load_o[2];
  logic [31:0] wb_o  [2];
  logic        opw_o [2];
  logic        sel_o [2];
  logic        vld_o [2];
  logic [4:0]  reg_o [2];
`ifdef MEM_WB_FORWARD_EN
  logic [4:0]  rs1, rs2;
  logic        hit1_o[2];
  logic        hit2_o[2];
  logic [31:0] fd1_o [2];
  logic [31:0] fd2_o [2];
`endif

  int checks = 0;
  int errors = 0;

  memory_writeback_pipe #(.DATA_WIDTH(32), .ADDRESS_BITS(20), .STAGES(2)) dut2 (
    .clock(clock), .reset(reset),
    .ALU_result_memory(alu_m), .load_data_memory(load_m),
    .opwrite_memory(opwrite_m), .opsel_memory(opsel_m),
    .opReg_memory(reg_m), .valid_memory(valid_m),
    .stall(stall), .flush(flush),
`ifdef MEM_WB_FORWARD_EN
    .fwd_rs1(rs1), .fwd_rs2(rs2),
    .fwd_hit1(hit1_o[0]), .fwd_hit2(hit2_o[0]),
    .fwd_data1(fd1_o[0]), .fwd_data2(fd2_o[0]),
`endif
    .ALU_result_writeback(alu_o[0]), .load_data_writeback(load_o[0]),
    .opwrite_writeback(opw_o[0]), .opsel_writeback(sel_o[0]),
    .opReg_writeback(reg_o[0]), .valid_writeback(vld_o[0]),
    .writeback_data(wb_o[0])
  );

  memory_writeback_pipe #(.DATA_WIDTH(32), .ADDRESS_BITS(20), .STAGES(3)) dut3 (
    .clock(clock), .reset(reset),
    .ALU_result_memory(alu_m), .load_data_memory(load_m),
    .opwrite_memory(opwrite_m), .opsel_memory(opsel_m),
    .opReg_memory(reg_m), .valid_memory(valid_m),
    .stall(stall), .flush(flush),
`ifdef MEM_WB_FORWARD_EN
    .fwd_rs1(rs1), .fwd_rs2(rs2),
    .fwd_hit1(hit1_o[1]), .fwd_hit2(hit2_o[1]),
    .fwd_data1(fd1_o[1]), .fwd_data2(fd2_o[1]),
`endif
    .ALU_result_writeback(alu_o[1]), .load_data_writeback(load_o[1]),
    .opwrite_writeback(opw_o[1]), .opsel_writeback(sel_o[1]),
    .opReg_writeback(reg_o[1]), .valid_writeback(vld_o[1]),
    .writeback_data(wb_o[1])
  );

  // Reference model: a history of accepted instructions; an S-deep pipe shows the S-th newest.
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] load;
    logic        opw;
    logic        sel;
    logic [4:0]  rd;
    logic        vld;
    logic        dc;
  } ent_t;

  ent_t hist[$];

  function automatic ent_t expect_at(int s);
    ent_t z = '0;
    if (hist.size() >= s) return hist[hist.size() - s];
    return z;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    ent_t n;
    if (reset) begin
      hist.delete();
    end else if (flush) begin
      foreach (hist[i]) begin
        hist[i].vld = 1'b0;
        hist[i].opw = 1'b0;
        hist[i].dc  = 1'b1;
      end
    end else if (!stall) begin
      n.alu  = alu_m;
      n.load = load_m;
      n.sel  = opsel_m;
      n.rd   = reg_m;
      n.vld  = valid_m;
      n.opw  = opwrite_m && valid_m && (reg_m != 5'd0);
      n.dc   = 1'b0;
      hist.push_back(n);
      if (hist.size() > 4) void'(hist.pop_front());
    end
  endtask

`ifdef MEM_WB_FORWARD_EN
  task automatic fwd_expect(int s, logic [4:0] rs, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = 32'd0;
    for (int j = 0; j < s; j++) begin
      int idx = hist.size() - 1 - j;
      if (!hit && idx >= 0 && rs != 5'd0 && hist[idx].vld && hist[idx].opw && hist[idx].rd == rs) begin
        hit  = 1'b1;
        data = hist[idx].sel ? hist[idx].load : hist[idx].alu;
      end
    end
  endtask
`endif

  task automatic check_dut(int d, int s);
    ent_t e = expect_at(s);
`ifdef MEM_WB_FORWARD_EN
    logic        h;
    logic [31:0] fd;
`endif
    check($sformatf("s%0d valid", s), 32'(vld_o[d]), 32'(e.vld));
    check($sformatf("s%0d opwrite", s), 32'(opw_o[d]), 32'(e.opw));
    if (!e.dc) begin
      check($sformatf("s%0d alu", s), alu_o[d], e.alu);
      check($sformatf("s%0d load", s), load_o[d], e.load);
      check($sformatf("s%0d opsel", s), 32'(sel_o[d]), 32'(e.sel));
      check($sformatf("s%0d opreg", s), 32'(reg_o[d]), 32'(e.rd));
      check($sformatf("s%0d wbdata", s), wb_o[d], e.sel ? e.load : e.alu);
    end
`ifdef MEM_WB_FORWARD_EN
    fwd_expect(s, rs1, h, fd);
    check($sformatf("s%0d hit1", s), 32'(hit1_o[d]), 32'(h));
    check($sformatf("s%0d fdata1", s), fd1_o[d], fd);
    fwd_expect(s, rs2, h, fd);
    check($sformatf("s%0d hit2", s), 32'(hit2_o[d]), 32'(h));
    check($sformatf("s%0d fdata2", s), fd2_o[d], fd);
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_dut(0, 2);
    check_dut(1, 3);
  endtask

  task automatic set_in(logic [31:0] a, logic [31:0] l, logic sel, logic [4:0] rd, logic w, logic v);
    alu_m     = a;
    load_m    = l;
    opsel_m   = sel;
    reg_m     = rd;
    opwrite_m = w;
    valid_m   = v;
  endtask

  task automatic idle();
    set_in($urandom, $urandom, 1'($urandom), 5'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
`ifdef MEM_WB_FORWARD_EN
    rs1 = 5'd0;
    rs2 = 5'd0;
`endif
    set_in(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 5'd3, 1'b1, 1'b1);
    tick();
    tick();
    check("reset wbdata s2", wb_o[0], 32'd0);
    check("reset wbdata s3", wb_o[1], 32'd0);
    check("reset valid s3", 32'(vld_o[1]), 32'd0);

    // Latency: entry on cycle 0 appears after 2 edges on the 2-stage pipe.
    reset = 1'b0;
    set_in(32'h11, 32'h22, 1'b1, 5'd5, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    check("lat wbdata", wb_o[0], 32'h22);
    check("lat opreg", 32'(reg_o[0]), 32'd5);
    check("lat opwrite", 32'(opw_o[0]), 32'd1);

    // x0 and invalid gating.
    set_in(32'h33, 32'h44, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    set_in(32'h55, 32'h66, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    check("x0 opwrite", 32'(opw_o[0]), 32'd0);
    check("x0 valid", 32'(vld_o[0]), 32'd1);
    idle();
    tick();
    check("inv opwrite", 32'(opw_o[0]), 32'd0);
    repeat (3) tick();

    // Stall on the 3-stage pipe: A at output, frozen, then B and C emerge.
    set_in(32'hA1, 32'hA2, 1'b0, 5'd1, 1'b1, 1'b1);
    tick();
    set_in(32'hB1, 32'hB2, 1'b0, 5'd2, 1'b1, 1'b1);
    tick();
    set_in(32'hC1, 32'hC2, 1'b1, 5'd3, 1'b1, 1'b1);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in($urandom, $urandom, 1'b1, 5'd31, 1'b1, 1'b1);
      tick();
      check("stall opreg", 32'(reg_o[1]), 32'd1);
      check("stall wbdata", wb_o[1], 32'hA1);
    end
    stall = 1'b0;
    idle();
    tick();
    check("unstall B", 32'(reg_o[1]), 32'd2);
    tick();
    check("unstall C", wb_o[1], 32'hC2);

    // Flush together with stall kills everything, including the input on that edge.
    for (int i = 0; i < 3; i++) begin
      set_in($urandom, $urandom, 1'($urandom), 5'(10 + i), 1'b1, 1'b1);
      tick();
    end
    set_in(32'h1313, 32'h1414, 1'b0, 5'd13, 1'b1, 1'b1);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    check("flush valid s2", 32'(vld_o[0]), 32'd0);
    check("flush valid s3", 32'(vld_o[1]), 32'd0);
    check("flush opwrite s3", 32'(opw_o[1]), 32'd0);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush drain valid", 32'(vld_o[1]), 32'd0);
    end

    // Reset while stalled.
    for (int i = 0; i < 3; i++) begin
      set_in($urandom | 32'h1, $urandom, 1'b0, 5'(20 + i), 1'b1, 1'b1);
      tick();
    end
    stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst stall wbdata", wb_o[1], 32'd0);
    check("rst stall opreg", 32'(reg_o[1]), 32'd0);
    check("rst stall valid", 32'(vld_o[0]), 32'd0);
    tick();
    stall = 1'b0;

`ifdef MEM_WB_FORWARD_EN
    // Youngest matching stage wins; register 0 never hits.
    set_in(32'hAA, 32'h0, 1'b0, 5'd9, 1'b1, 1'b1);
    tick();
    set_in(32'h0, 32'hBB, 1'b1, 5'd9, 1'b1, 1'b1);
    rs1 = 5'd9;
    rs2 = 5'd0;
    tick();
    check("fwd hit1", 32'(hit1_o[0]), 32'd1);
    check("fwd data1", fd1_o[0], 32'hBB);
    check("fwd hit2", 32'(hit2_o[0]), 32'd0);
    check("fwd data2", fd2_o[0], 32'd0);
`endif

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom % 50) == 0;
      flush = ($urandom % 20) == 0;
      stall = ($urandom % 5) == 0;
      set_in($urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 7)),
             1'($urandom), ($urandom % 4) != 0);
`ifdef MEM_WB_FORWARD_EN
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
`endif
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
